rtc_bcd_timebase: RTL and testbench
===================================

Name: rtc_bcd_timebase

Overview:
Free-running BCD time-of-day counter clocked from CLOCK_50, with a programmable alarm. It feeds the display/decoder stage with a packed 32-bit BCD time word in HH:MM:SS.hh format. It drives alarm_sound. Field loads come from the board switch/button front end and are range-checked before they are written.

Parameters:
TICK_DIV, 500000, CLOCK_50 cycles per hundredth-second tick (50 MHz / 100 Hz); benches use 4.
ALARM_TICKS, 1000, alarm ring duration in ticks (10 s at the default).

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = timebase advances; 0 = time frozen, divider held
load_time  in  1  single-cycle strobe: write load_value into time field load_field
load_alarm  in  1  single-cycle strobe: write load_value into alarm field load_field
load_field  in  2  3=hours [31:24], 2=minutes [23:16], 1=seconds [15:8], 0=hundredths [7:0]
load_value  in  8  two BCD digits
alarm_en  in  1  arms alarm compare
alarm_clear  in  1  silences a ringing alarm
time_out  out  32  packed BCD current time
alarm_out  out  32  packed BCD alarm setting
tick  out  1  one-cycle pulse per hundredth-second increment
alarm_sound  out  1  high while ringing
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset, synchronous, active-high; wins over everything:
  - time_out = 0, alarm_out = 0, divider = 0.
  - tick, alarm_sound, load_err = 0; state = IDLE; ring counter = 0.
- Divider:
  - While run=1, counts 0..TICK_DIV-1.
  - On the edge where it is at TICK_DIV-1, it wraps to 0 and the time increments; tick is high for the following cycle.
  - run=0: divider and time both hold; tick = 0.
- Increment is a BCD ripple:
  - hundredths 99→00 carries into seconds;
  - seconds 59→00 carries into minutes;
  - minutes 59→00 carries into hours;
  - hours 23→00.
  - 23:59:59.99 → 00:00:00.00 in one tick.
  - Only BCD values ever appear; no binary intermediates are visible.
- Load validity:
  - Both nibbles must be ≤ 9.
  - Value must be ≤ 23 for hours, ≤ 59 for minutes/seconds, ≤ 99 for hundredths.
  - Valid load writes the addressed field on the next edge; no other field changes.
  - Invalid load writes nothing and load_err pulses on the next cycle.
- load_time side effects:
  - A valid load_time also clears the divider to 0.
  - Any tick increment due that same edge is discarded, so the loaded value holds a full tick period.
- load_time and load_alarm in the same cycle: both are applied with the same field/value. load_err pulses once if the value is invalid.
- Alarm FSM, states IDLE and RINGING:
  - IDLE→RINGING: alarm_en=1, alarm_clear=0, and a tick increment makes the new time equal alarm_out (full 32-bit compare).
    - Loads never trigger the alarm, even if they make the values equal.
    - The ring counter is set to 0.
  - alarm_sound = 1 exactly while in RINGING (registered output).
  - In RINGING, the ring counter increments on each tick.
  - RINGING→IDLE when any of these occur:
    - the counter reaches ALARM_TICKS-1 on a tick;
    - alarm_clear=1;
    - alarm_en=0;
    - reset.
  - Ringing persists while run=0, because no ticks arrive to advance the counter.
  - alarm_clear and a match in the same cycle: clear wins and the state stays IDLE.
  - A new match while already RINGING does not restart the counter.
- Default alarm 00:00:00.00 with alarm_en=1 rings at midnight rollover.

Test Plan:
1. Bench uses TICK_DIV=4, ALARM_TICKS=3. Release reset, run=1 → first tick pulse on the 5th cycle after reset deasserts; time_out 0x00000000→0x00000001; thereafter one tick every 4 cycles.
2. Rollover:
   - Load 23/59/59/99 (fields 3..0), run one tick → time_out = 0x00000000.
   - Load 09:59:59.99, one tick → time_out = 0x10000000.
3. Load rejection:
   - load_time field 2 value 0x60 → load_err pulses one cycle, minutes unchanged.
   - field 0 value 0x1A → rejected.
   - field 3 value 0x23 → accepted.
4. Load vs tick collision: load_time field 0 value 0x50 on the cycle a tick is due → time_out[7:0] = 0x50; the next increment to 0x51 occurs 4 cycles later.
5. Alarm ring:
   - alarm = 00:00:01.00, alarm_en=1, time = 00:00:00.99, one tick → alarm_sound rises the next cycle.
   - alarm_sound falls after 3 ticks.
   - Repeat with alarm_clear pulsed mid-ring → falls the next cycle.
6. Non-triggers:
   - A load_time that makes time equal the alarm → no ring.
   - run=0 during ring → alarm_sound stays 1 and time is frozen.
   - reset mid-ring → all outputs 0 on the next edge.

Source files
------------

// File: rtl/rtc_bcd_timebase.sv
// BCD time-of-day counter (HH:MM:SS.hh) with range-checked field loads
// and a single programmable alarm that rings for a fixed number of ticks.
//
// Ports:
//   CLOCK_50     system clock
//   reset        synchronous, active-high reset
//   run          1 = timebase advances, 0 = time and divider frozen
//   load_time    strobe: write load_value into time field load_field
//   load_alarm   strobe: write load_value into alarm field load_field
//   load_field   3=hours 2=minutes 1=seconds 0=hundredths
//   load_value   two BCD digits
//   alarm_en     arms the alarm compare
//   alarm_clear  silences a ringing alarm
//   time_out     packed BCD current time
//   alarm_out    packed BCD alarm setting
//   tick         one-cycle pulse after each hundredth increment
//   alarm_sound  high while ringing
//   load_err     one-cycle pulse after a rejected load
module rtc_bcd_timebase #(
    parameter int TICK_DIV    = 500000,
    parameter int ALARM_TICKS = 1000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        run,
    input  logic        load_time,
    input  logic        load_alarm,
    input  logic [1:0]  load_field,
    input  logic [7:0]  load_value,
    input  logic        alarm_en,
    input  logic        alarm_clear,
    output logic [31:0] time_out,
    output logic [31:0] alarm_out,
    output logic        tick,
    output logic        alarm_sound,
    output logic        load_err
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(ALARM_TICKS - 1);

    typedef enum logic {
        IDLE,
        RINGING
    } state_t;

    state_t          state_q, state_n;
    logic [DW-1:0]   div_q;
    logic [RW-1:0]   ring_q, ring_n;

    logic [7:0]      lim;
    logic            load_ok;
    logic            time_ld;
    logic            wrap;
    logic            inc;
    logic            match;
    logic [31:0]     time_inc;
    logic [31:0]     time_ldv;
    logic [31:0]     alarm_ldv;
    logic            c_top, s_top, m_top;

    // Two-digit BCD successor; wraps to 00 past top.
    function automatic logic [7:0] step2(
        input logic [7:0] v,
        input logic [7:0] top
    );
        if (v == top)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        lim = 8'h99;
        unique case (load_field)
            2'd3:    lim = 8'h23;
            2'd2:    lim = 8'h59;
            2'd1:    lim = 8'h59;
            default: lim = 8'h99;
        endcase
    end

    // With both digits <= 9 the packed BCD byte orders like its value.
    assign load_ok = (load_value[7:4] <= 4'd9)
                  && (load_value[3:0] <= 4'd9)
                  && (load_value <= lim);

    assign time_ld = load_time && load_ok;
    assign wrap    = run && (div_q == DIV_LAST);
    // A time load takes the edge; the pending increment is dropped.
    assign inc     = wrap && !time_ld;

    assign c_top = (time_out[7:0]   == 8'h99);
    assign s_top = (time_out[15:8]  == 8'h59);
    assign m_top = (time_out[23:16] == 8'h59);

    always_comb begin
        time_inc[7:0]   = step2(time_out[7:0], 8'h99);
        time_inc[15:8]  = c_top
                        ? step2(time_out[15:8], 8'h59)
                        : time_out[15:8];
        time_inc[23:16] = (c_top && s_top)
                        ? step2(time_out[23:16], 8'h59)
                        : time_out[23:16];
        time_inc[31:24] = (c_top && s_top && m_top)
                        ? step2(time_out[31:24], 8'h23)
                        : time_out[31:24];
    end

    always_comb begin
        time_ldv  = time_out;
        alarm_ldv = alarm_out;
        time_ldv[{load_field, 3'b000} +: 8]  = load_value;
        alarm_ldv[{load_field, 3'b000} +: 8] = load_value;
    end

    assign match = inc && alarm_en && (time_inc == alarm_out);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_q     <= '0;
            time_out  <= '0;
            alarm_out <= '0;
            tick      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            if (time_ld)
                div_q <= '0;
            else if (wrap)
                div_q <= '0;
            else if (run)
                div_q <= div_q + 1'b1;

            if (time_ld)
                time_out <= time_ldv;
            else if (inc)
                time_out <= time_inc;

            if (load_alarm && load_ok)
                alarm_out <= alarm_ldv;

            tick     <= inc;
            load_err <= (load_time || load_alarm) && !load_ok;
        end
    end

    always_comb begin
        state_n = state_q;
        ring_n  = ring_q;
        unique case (state_q)
            IDLE: begin
                if (match && !alarm_clear) begin
                    state_n = RINGING;
                    ring_n  = '0;
                end
            end
            RINGING: begin
                if (alarm_clear || !alarm_en)
                    state_n = IDLE;
                else if (inc) begin
                    if (ring_q == RING_LAST)
                        state_n = IDLE;
                    else
                        ring_n = ring_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            ring_q  <= '0;
        end else begin
            state_q <= state_n;
            ring_q  <= ring_n;
        end
    end

    assign alarm_sound = (state_q == RINGING);

endmodule

// File: tb/tb_rtc_bcd_timebase.sv
// Bench for rtc_bcd_timebase: directed vectors, literal checks and an
// every-cycle compare against an integer time-of-day model.
module tb_rtc_bcd_timebase;

    localparam int DIV  = 4;
    localparam int RING = 3;
    localparam int DAY  = 8640000;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        load_time = 1'b0;
    logic        load_alarm = 1'b0;
    logic [1:0]  load_field = 2'd0;
    logic [7:0]  load_value = 8'h00;
    logic        alarm_en = 1'b0;
    logic        alarm_clear = 1'b0;
    logic [31:0] time_out;
    logic [31:0] alarm_out;
    logic        tick;
    logic        alarm_sound;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: times as hundredths since midnight
    int m_t = 0;
    int m_a = 0;
    int m_div = 0;
    int m_rc = 0;
    bit m_tick = 0;
    bit m_err = 0;
    bit m_ring = 0;

    rtc_bcd_timebase #(
        .TICK_DIV(DIV),
        .ALARM_TICKS(RING)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .run(run),
        .load_time(load_time),
        .load_alarm(load_alarm),
        .load_field(load_field),
        .load_value(load_value),
        .alarm_en(alarm_en),
        .alarm_clear(alarm_clear),
        .time_out(time_out),
        .alarm_out(alarm_out),
        .tick(tick),
        .alarm_sound(alarm_sound),
        .load_err(load_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] b2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] to_bcd(input int x);
        int h, m, s, c;
        h = x / 360000;
        m = (x / 6000) % 60;
        s = (x / 100) % 60;
        c = x % 100;
        return {b2(h), b2(m), b2(s), b2(c)};
    endfunction

    function automatic bit valid(input logic [7:0] v, input logic [1:0] f);
        int hi, lo, lim;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        lim = (f == 2'd3) ? 23 : (f == 2'd0) ? 99 : 59;
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= lim);
    endfunction

    function automatic int set_field(input int x, input logic [1:0] f,
                                     input logic [7:0] v);
        int h, m, s, c, d;
        h = x / 360000;
        m = (x / 6000) % 60;
        s = (x / 100) % 60;
        c = x % 100;
        d = int'(v[7:4]) * 10 + int'(v[3:0]);
        case (f)
            2'd3: h = d;
            2'd2: m = d;
            2'd1: s = d;
            default: c = d;
        endcase
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    always @(posedge CLOCK_50) begin : model
        int nt, na, rc;
        bit rg, ok, tl, inc;
        if (reset) begin
            m_t <= 0; m_a <= 0; m_div <= 0; m_rc <= 0;
            m_tick <= 0; m_err <= 0; m_ring <= 0;
        end else begin
            ok  = valid(load_value, load_field);
            tl  = load_time && ok;
            inc = run && (m_div == DIV - 1) && !tl;
            nt  = inc ? (m_t + 1) % DAY : m_t;
            na  = m_a;
            rg  = m_ring;
            rc  = m_rc;
            if (m_ring) begin
                if (alarm_clear || !alarm_en)
                    rg = 0;
                else if (inc) begin
                    if (m_rc == RING - 1) rg = 0;
                    else rc = m_rc + 1;
                end
            end else if (inc && alarm_en && !alarm_clear && nt == m_a) begin
                rg = 1;
                rc = 0;
            end
            if (tl) nt = set_field(nt, load_field, load_value);
            if (load_alarm && ok) na = set_field(na, load_field, load_value);
            m_div  <= tl ? 0 : !run ? m_div : (m_div == DIV - 1) ? 0 : m_div + 1;
            m_t    <= nt;
            m_a    <= na;
            m_ring <= rg;
            m_rc   <= rc;
            m_tick <= inc;
            m_err  <= (load_time || load_alarm) && !ok;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("model time_out", time_out, to_bcd(m_t));
            check("model alarm_out", alarm_out, to_bcd(m_a));
            check("model tick", 32'(tick), 32'(m_tick));
            check("model alarm_sound", 32'(alarm_sound), 32'(m_ring));
            check("model load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic ld(input bit t, input bit a, input logic [1:0] f,
                      input logic [7:0] v);
        load_time  = t;
        load_alarm = a;
        load_field = f;
        load_value = v;
        cyc();
        load_time  = 1'b0;
        load_alarm = 1'b0;
    endtask

    task automatic set_time(input logic [31:0] w);
        ld(1, 0, 2'd3, w[31:24]);
        ld(1, 0, 2'd2, w[23:16]);
        ld(1, 0, 2'd1, w[15:8]);
        ld(1, 0, 2'd0, w[7:0]);
    endtask

    initial begin
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset time", time_out, 32'h0);
        check("reset sound", 32'(alarm_sound), 32'h0);

        // first tick on the 5th cycle after reset release
        reset = 1'b0;
        run   = 1'b1;
        cyc(3);
        check("no early tick", 32'(tick), 32'h0);
        cyc();
        check("first tick", 32'(tick), 32'h1);
        check("first inc", time_out, 32'h00000001);
        cyc(4);
        check("second inc", time_out, 32'h00000002);

        // rollovers
        set_time(32'h23595999);
        cyc(4);
        check("midnight roll", time_out, 32'h00000000);
        set_time(32'h09595999);
        cyc(4);
        check("hour carry", time_out, 32'h10000000);

        // load rejection
        ld(1, 0, 2'd2, 8'h60);
        check("err min 60", 32'(load_err), 32'h1);
        check("min kept", 32'(time_out[23:16]), 32'h00);
        cyc();
        check("err one cycle", 32'(load_err), 32'h0);
        ld(1, 0, 2'd0, 8'h1A);
        check("err hund 1A", 32'(load_err), 32'h1);
        ld(1, 0, 2'd3, 8'h23);
        check("hr 23 ok", 32'(load_err), 32'h0);
        check("hr 23 val", 32'(time_out[31:24]), 32'h23);

        // load lands on the edge a tick was due
        cyc(3);
        ld(1, 0, 2'd0, 8'h50);
        check("coll val", 32'(time_out[7:0]), 32'h50);
        check("coll no tick", 32'(tick), 32'h0);
        cyc(3);
        check("coll hold", 32'(time_out[7:0]), 32'h50);
        cyc();
        check("coll next", 32'(time_out[7:0]), 32'h51);

        // dual load, valid then invalid
        ld(1, 1, 2'd2, 8'h45);
        check("dual alarm", alarm_out, 32'h00450000);
        ld(1, 1, 2'd2, 8'h9A);
        check("dual err", 32'(load_err), 32'h1);
        cyc();
        check("dual err once", 32'(load_err), 32'h0);

        // alarm ring to timeout
        ld(0, 1, 2'd2, 8'h00);
        ld(0, 1, 2'd1, 8'h01);
        alarm_en = 1'b1;
        set_time(32'h00000099);
        cyc(4);
        check("ring time", time_out, 32'h00000100);
        check("ring start", 32'(alarm_sound), 32'h1);
        cyc(8);
        check("ring 2 ticks", 32'(alarm_sound), 32'h1);
        cyc(4);
        check("ring end", 32'(alarm_sound), 32'h0);

        // clear mid-ring
        set_time(32'h00000099);
        cyc(4);
        check("ring2 start", 32'(alarm_sound), 32'h1);
        cyc(5);
        alarm_clear = 1'b1;
        cyc();
        alarm_clear = 1'b0;
        check("clear stop", 32'(alarm_sound), 32'h0);

        // clear coincident with match
        set_time(32'h00000099);
        cyc(3);
        alarm_clear = 1'b1;
        cyc();
        alarm_clear = 1'b0;
        check("clear beats match", 32'(alarm_sound), 32'h0);

        // load equal to alarm never rings
        set_time(32'h00000100);
        cyc(2);
        check("load no ring", 32'(alarm_sound), 32'h0);

        // frozen ring
        set_time(32'h00000099);
        cyc(4);
        run = 1'b0;
        cyc(10);
        check("frozen sound", 32'(alarm_sound), 32'h1);
        check("frozen time", time_out, 32'h00000100);
        run = 1'b1;
        cyc(2);

        // reset mid-ring
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst time", time_out, 32'h0);
        check("rst alarm", alarm_out, 32'h0);
        check("rst sound", 32'(alarm_sound), 32'h0);
        check("rst tick", 32'(tick), 32'h0);

        // default alarm rings at midnight
        set_time(32'h23595999);
        cyc(4);
        check("midnight ring", 32'(alarm_sound), 32'h1);
        alarm_en = 1'b0;
        cyc();
        check("disarm stop", 32'(alarm_sound), 32'h0);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
